// File: rtl/fetch_pc.sv
// Program counter and next-PC resolution for the P4 single-cycle MIPS core.
// Define FETCH_PC_RANGE_CHECK_EN to compile in the sticky fetch-address error flag.
module fetch_pc #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int          IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npc_op,
    input  logic        br_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] index26,
    input  logic [31:0] rs_data,
    output logic [31:0] pc,
    output logic [31:0] pc_plus8,
    output logic [31:0] fetch_cnt,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        NPC_SEQ = 2'b00,
        NPC_BR  = 2'b01,
        NPC_J   = 2'b10,
        NPC_JR  = 2'b11
    } npc_op_e;

    localparam logic [31:0] PC_LAST = PC_RESET + 32'(IM_WORDS * 4) - 32'd4;

    logic [31:0] pc_d, pc_q;
    logic [31:0] fetch_cnt_d, fetch_cnt_q;
    logic [31:0] pc_seq;
    logic [31:0] br_off;
    logic [31:0] npc;

    assign pc_seq = pc_q + 32'd4;
    assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        npc = pc_seq;
        unique case (npc_op_e'(npc_op))
            NPC_SEQ: npc = pc_seq;
            NPC_BR:  npc = br_taken ? pc_seq + br_off : pc_seq;
            // Region bits come from the current pc, not pc + 4.
            NPC_J:   npc = {pc_q[31:28], index26, 2'b00};
            NPC_JR:  npc = {rs_data[31:2], 2'b00};
            default: npc = pc_seq;
        endcase
    end

    always_comb begin
        pc_d        = pc_q;
        fetch_cnt_d = fetch_cnt_q;
        if (!stall) begin
            pc_d        = npc;
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering; comb blocks use blocking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= PC_RESET;
            fetch_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

`ifdef FETCH_PC_RANGE_CHECK_EN
    logic addr_err_d, addr_err_q;
    logic out_of_window;
    logic jr_misaligned;

    assign out_of_window = (npc < PC_RESET) || (npc > PC_LAST);
    assign jr_misaligned = (npc_op_e'(npc_op) == NPC_JR) && (rs_data[1:0] != 2'b00);

    always_comb begin
        addr_err_d = addr_err_q;
        if (!stall && (out_of_window || jr_misaligned)) begin
            addr_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= addr_err_d;
        end
    end

    assign addr_err = addr_err_q;
`else
    // Misaligned jr targets are aligned silently; these bits feed nothing.
    logic unused_chk;
    assign unused_chk = ^{rs_data[1:0], PC_LAST};
    assign addr_err   = 1'b0;
`endif

    assign pc        = pc_q;
    assign pc_plus8  = pc_q + 32'd8;
    assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_pc.sv
// Self-checking bench for fetch_pc: directed scenarios followed by random
// traffic compared against an arithmetic reference model.
module tb_fetch_pc;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam int          IM_WORDS = 4096;
    localparam longint      WIN_LO   = longint'(PC_RESET);
    localparam longint      WIN_HI   = longint'(PC_RESET) + 4 * longint'(IM_WORDS) - 4;
`ifdef FETCH_PC_RANGE_CHECK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [1:0]  npc_op;
    logic        br_taken;
    logic [15:0] imm16;
    logic [25:0] index26;
    logic [31:0] rs_data;
    logic [31:0] pc;
    logic [31:0] pc_plus8;
    logic [31:0] fetch_cnt;
    logic        addr_err;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic        m_err;

    fetch_pc #(.PC_RESET(PC_RESET), .IM_WORDS(IM_WORDS)) dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .npc_op   (npc_op),
        .br_taken (br_taken),
        .imm16    (imm16),
        .index26  (index26),
        .rs_data  (rs_data),
        .pc       (pc),
        .pc_plus8 (pc_plus8),
        .fetch_cnt(fetch_cnt),
        .addr_err (addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"}, pc, m_pc);
        check({tag, ".pc_plus8"}, pc_plus8, m_pc + 32'd8);
        check({tag, ".fetch_cnt"}, fetch_cnt, m_cnt);
        check({tag, ".addr_err"}, {31'd0, addr_err}, {31'd0, m_err});
    endtask

    // Reference next-PC, written from the architectural rules with plain arithmetic.
    function automatic logic [31:0] ref_npc(input logic [31:0] cur, input logic [1:0] op,
                                            input logic taken, input logic [15:0] imm,
                                            input logic [25:0] idx, input logic [31:0] rs);
        int signed off_words;
        off_words = int'($signed(imm));
        case (op)
            2'd0:    return cur + 32'd4;
            2'd1:    return taken ? cur + 32'd4 + 32'(off_words * 4) : cur + 32'd4;
            2'd2:    return (cur & 32'hF000_0000) | (32'(idx) * 32'd4);
            default: return rs & ~32'd3;
        endcase
    endfunction

    // Drive one cycle of inputs, advance the model, and check just after the edge.
    task automatic apply(input string tag, input logic st, input logic [1:0] op,
                         input logic taken, input logic [15:0] imm,
                         input logic [25:0] idx, input logic [31:0] rs);
        logic [31:0] nxt;
        stall    = st;
        npc_op   = op;
        br_taken = taken;
        imm16    = imm;
        index26  = idx;
        rs_data  = rs;
        nxt = ref_npc(m_pc, op, taken, imm, idx, rs);
        @(posedge clk);
        #1;
        if (!st) begin
            if (RANGE_CHK && (longint'(nxt) < WIN_LO || longint'(nxt) > WIN_HI ||
                              (op == 2'd3 && rs[1:0] != 2'd0)))
                m_err = 1'b1;
            m_pc  = nxt;
            m_cnt = m_cnt + 32'd1;
        end
        check_all(tag);
    endtask

    // Assert reset between edges, check the asynchronous effect, hold across an edge, release.
    task automatic pulse_reset(input string tag);
        #3;
        reset = 1'b1;
        stall = 1'b0;
        #1;
        m_pc  = PC_RESET;
        m_cnt = '0;
        m_err = 1'b0;
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        stall    = 1'b0;
        npc_op   = 2'd0;
        br_taken = 1'b0;
        imm16    = '0;
        index26  = '0;
        rs_data  = '0;
        m_pc     = PC_RESET;
        m_cnt    = '0;
        m_err    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("por");
        reset = 1'b0;

        for (int i = 0; i < 3; i++) apply("seq", 1'b0, 2'd0, 1'b0, '0, '0, '0);
        check("seq3.pc", pc, 32'h0000_300C);
        check("seq3.cnt", fetch_cnt, 32'd3);

        pulse_reset("rst_mid");
        apply("seq", 1'b0, 2'd0, 1'b0, '0, '0, '0);
        check("rst_first_edge.pc", pc, 32'h0000_3004);

        apply("jr3010", 1'b0, 2'd3, 1'b0, '0, '0, 32'h0000_3010);
        apply("br_taken", 1'b0, 2'd1, 1'b1, 16'hFFFC, '0, '0);
        check("br_taken.pc", pc, 32'h0000_3004);
        for (int i = 0; i < 3; i++) apply("seq", 1'b0, 2'd0, 1'b0, '0, '0, '0);
        apply("br_not", 1'b0, 2'd1, 1'b0, 16'hFFFC, '0, '0);
        check("br_not.pc", pc, 32'h0000_3014);
        apply("self_loop", 1'b0, 2'd1, 1'b1, 16'hFFFF, '0, '0);
        check("self_loop.pc", pc, 32'h0000_3014);

        apply("jr3000", 1'b0, 2'd3, 1'b0, '0, '0, 32'h0000_3000);
        apply("j", 1'b0, 2'd2, 1'b0, '0, 26'h0000C10, '0);
        check("j.pc", pc, 32'h0000_3040);
        apply("jr_mis", 1'b0, 2'd3, 1'b0, '0, '0, 32'h0000_3103);
        check("jr_mis.pc", pc, 32'h0000_3100);
        check("jr_mis.err", {31'd0, addr_err}, {31'd0, RANGE_CHK});

        for (int i = 0; i < 4; i++) apply("stall_j", 1'b1, 2'd2, 1'b0, '0, 26'h3FFFFFF, '0);
        apply("stall_br", 1'b1, 2'd1, 1'b1, 16'h0100, '0, '0);
        check("stall.pc", pc, 32'h0000_3100);
        apply("seq", 1'b0, 2'd0, 1'b0, '0, '0, '0);
        check("sticky.err", {31'd0, addr_err}, {31'd0, RANGE_CHK});

        pulse_reset("rst_range");
        apply("br_low", 1'b0, 2'd1, 1'b1, 16'hFFFE, '0, '0);
        check("br_low.pc", pc, 32'h0000_2FFC);
        check("br_low.err", {31'd0, addr_err}, {31'd0, RANGE_CHK});

        pulse_reset("rst_wrap");
        apply("jr_top", 1'b0, 2'd3, 1'b0, '0, '0, 32'hFFFF_FFFC);
        apply("wrap", 1'b0, 2'd0, 1'b0, '0, '0, '0);
        check("wrap.pc", pc, 32'h0000_0000);

        pulse_reset("rst_rand");
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rs;
            logic        st;
            st = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 1) == 0)
                 ? PC_RESET + 32'($urandom_range(0, 4 * IM_WORDS - 1))
                 : $urandom;
            if (i % 97 == 96) pulse_reset("rst_rand");
            apply("rand", st, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  16'($urandom_range(0, 16'hFFFF)), 26'($urandom), rs);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
